// File: rtl/dem_phut_gio.sv
// dem_phut_gio: packed-BCD minute/hour counter with minute/hour edit modes and a day-rollover pulse.
// Build option: define HOUR12_EN for 12-hour counting with a PM flag (default is 24-hour).
`default_nettype none

module dem_phut_gio (
   input  logic       clk_1Hz,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [2:0] mode,
   input  logic [7:0] giay,
   output logic [7:0] phut,
   output logic [7:0] gio,
   output logic       pm,
   output logic       carry_ngay
);

   localparam logic [2:0] c_MODE_SEC  = 3'b111;
   localparam logic [2:0] c_MODE_MIN  = 3'b101;
   localparam logic [2:0] c_MODE_HOUR = 3'b011;
`ifdef HOUR12_EN
   localparam logic [7:0] c_GIO_RST   = 8'h12;
`else
   localparam logic [7:0] c_GIO_RST   = 8'h00;
`endif

   logic [7:0] r_phut, r_gio;
   logic       r_carry;
   logic [7:0] w_phut_nxt, w_gio_nxt;
   logic       w_carry_nxt;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
   endfunction

   // Hour step with range wrap; shared by run carry and hour edit.
   function automatic logic [7:0] gio_up(input logic [7:0] v);
`ifdef HOUR12_EN
      return (v == 8'h12) ? 8'h01 : bcd_inc(v);
`else
      return (v == 8'h23) ? 8'h00 : bcd_inc(v);
`endif
   endfunction

   function automatic logic [7:0] gio_dn(input logic [7:0] v);
`ifdef HOUR12_EN
      return (v == 8'h01) ? 8'h12 : bcd_dec(v);
`else
      return (v == 8'h00) ? 8'h23 : bcd_dec(v);
`endif
   endfunction

`ifdef HOUR12_EN
   logic r_pm;
   logic w_pm_nxt;
`endif

   always_comb begin
      w_phut_nxt  = r_phut;
      w_gio_nxt   = r_gio;
      w_carry_nxt = 1'b0;
`ifdef HOUR12_EN
      w_pm_nxt    = r_pm;
`endif
      case (mode)
         c_MODE_SEC: begin
            // seconds frozen upstream: hold everything
         end
         c_MODE_MIN: begin
            if (!btn_up)
               w_phut_nxt = (r_phut == 8'h59) ? 8'h00 : bcd_inc(r_phut);
            else if (!btn_down)
               w_phut_nxt = (r_phut == 8'h00) ? 8'h59 : bcd_dec(r_phut);
         end
         c_MODE_HOUR: begin
            if (!btn_up)
               w_gio_nxt = gio_up(r_gio);
            else if (!btn_down)
               w_gio_nxt = gio_dn(r_gio);
         end
         default: begin
            if (giay == 8'h59) begin
               if (r_phut == 8'h59) begin
                  w_phut_nxt = 8'h00;
                  w_gio_nxt  = gio_up(r_gio);
`ifdef HOUR12_EN
                  if (r_gio == 8'h11) begin
                     w_pm_nxt    = ~r_pm;
                     w_carry_nxt = r_pm;
                  end
`else
                  w_carry_nxt = (r_gio == 8'h23);
`endif
               end else begin
                  w_phut_nxt = bcd_inc(r_phut);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_1Hz) begin
      if (!rst_n) begin
         r_phut  <= 8'h00;
         r_gio   <= c_GIO_RST;
         r_carry <= 1'b0;
      end else begin
         r_phut  <= w_phut_nxt;
         r_gio   <= w_gio_nxt;
         r_carry <= w_carry_nxt;
      end
   end

`ifdef HOUR12_EN
   always_ff @(posedge clk_1Hz) begin
      if (!rst_n)
         r_pm <= 1'b0;
      else
         r_pm <= w_pm_nxt;
   end
   assign pm = r_pm;
`else
   assign pm = 1'b0;
`endif

   assign phut       = r_phut;
   assign gio        = r_gio;
   assign carry_ngay = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_dem_phut_gio.sv
// tb_dem_phut_gio: table-driven directed check of dem_phut_gio (24h default; 12h rows when HOUR12_EN is defined).
`default_nettype none

module tb_dem_phut_gio;

   logic       clk_1Hz = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_up = 1'b1;
   logic       btn_down = 1'b1;
   logic [2:0] mode = 3'b000;
   logic [7:0] giay = 8'h00;
   logic [7:0] phut, gio;
   logic       pm, carry_ngay;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       rst_n;
      logic       up;
      logic       dn;
      logic [2:0] mode;
      logic [7:0] giay;
      logic [7:0] e_phut;
      logic [7:0] e_gio;
      logic       e_pm;
      logic       e_carry;
   } vec_t;

   vec_t vecs[$];

`ifdef HOUR12_EN
   localparam logic [7:0] c_GIO_RST = 8'h12;
`else
   localparam logic [7:0] c_GIO_RST = 8'h00;
`endif

   dem_phut_gio dut (
      .clk_1Hz    (clk_1Hz),
      .rst_n      (rst_n),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .mode       (mode),
      .giay       (giay),
      .phut       (phut),
      .gio        (gio),
      .pm         (pm),
      .carry_ngay (carry_ngay)
   );

   always #5 clk_1Hz = ~clk_1Hz;

   task automatic add(input logic r, input logic u, input logic d, input logic [2:0] m,
                      input logic [7:0] g, input logic [7:0] ep, input logic [7:0] eg,
                      input logic epm, input logic ec);
      vec_t v;
      v.rst_n = r; v.up = u; v.dn = d; v.mode = m; v.giay = g;
      v.e_phut = ep; v.e_gio = eg; v.e_pm = epm; v.e_carry = ec;
      vecs.push_back(v);
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one vector, clock one edge, check registered outputs 1 time unit later.
   task automatic apply(input string tag, input vec_t v);
      rst_n = v.rst_n; btn_up = v.up; btn_down = v.dn; mode = v.mode; giay = v.giay;
      @(posedge clk_1Hz);
      #1;
      chk8({tag, " phut"}, phut, v.e_phut);
      chk8({tag, " gio"}, gio, v.e_gio);
      chk8({tag, " pm"}, {7'd0, pm}, {7'd0, v.e_pm});
      chk8({tag, " carry_ngay"}, {7'd0, carry_ngay}, {7'd0, v.e_carry});
   endtask

   initial begin
      vec_t hv;
      // rst up dn mode giay -> phut gio pm carry
      add(0, 1, 1, 3'b000, 8'h59, 8'h00, c_GIO_RST, 0, 0);
`ifdef HOUR12_EN
      add(1, 1, 0, 3'b011, 8'h00, 8'h00, 8'h11, 0, 0);
      add(1, 1, 0, 3'b101, 8'h00, 8'h59, 8'h11, 0, 0);
      add(1, 1, 1, 3'b000, 8'h59, 8'h00, 8'h12, 1, 0);  // 11:59 AM -> 12 PM
      add(1, 1, 0, 3'b011, 8'h59, 8'h00, 8'h11, 1, 0);
      add(1, 1, 0, 3'b101, 8'h00, 8'h59, 8'h11, 1, 0);
      add(1, 1, 1, 3'b000, 8'h59, 8'h00, 8'h12, 0, 1);  // 11:59 PM -> 12 AM
      add(1, 1, 1, 3'b000, 8'h00, 8'h00, 8'h12, 0, 0);
      add(1, 1, 1, 3'b000, 8'h59, 8'h01, 8'h12, 0, 0);
      add(1, 1, 1, 3'b000, 8'h59, 8'h02, 8'h12, 0, 0);
      add(1, 0, 1, 3'b011, 8'h00, 8'h02, 8'h01, 0, 0);
      add(1, 1, 0, 3'b011, 8'h00, 8'h02, 8'h12, 0, 0);
      add(1, 0, 0, 3'b011, 8'h00, 8'h02, 8'h01, 0, 0);
`else
      add(1, 1, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0);
      add(1, 1, 0, 3'b101, 8'h00, 8'h59, 8'h00, 0, 0);
      add(1, 0, 0, 3'b101, 8'h00, 8'h00, 8'h00, 0, 0);
      add(1, 1, 1, 3'b101, 8'h59, 8'h00, 8'h00, 0, 0);
      add(1, 0, 1, 3'b101, 8'h00, 8'h01, 8'h00, 0, 0);
      add(1, 1, 0, 3'b011, 8'h00, 8'h01, 8'h23, 0, 0);
      add(1, 0, 1, 3'b011, 8'h00, 8'h01, 8'h00, 0, 0);
      add(1, 1, 0, 3'b011, 8'h59, 8'h01, 8'h23, 0, 0);
      add(1, 1, 0, 3'b101, 8'h00, 8'h00, 8'h23, 0, 0);
      add(1, 1, 0, 3'b101, 8'h00, 8'h59, 8'h23, 0, 0);
      for (int i = 0; i < 5; i++)
         add(1, 1, 1, 3'b111, 8'h59, 8'h59, 8'h23, 0, 0);
      add(1, 1, 1, 3'b000, 8'h59, 8'h00, 8'h00, 0, 1);  // 23:59:59 rollover
      add(1, 1, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0);
      add(1, 1, 0, 3'b101, 8'h00, 8'h59, 8'h00, 0, 0);
      add(1, 1, 1, 3'b000, 8'h59, 8'h00, 8'h01, 0, 0);
      add(1, 1, 1, 3'b000, 8'h58, 8'h00, 8'h01, 0, 0);
      add(1, 1, 1, 3'b000, 8'h59, 8'h01, 8'h01, 0, 0);
      for (int i = 2; i <= 9; i++)
         add(1, 0, 1, 3'b101, 8'h00, 8'(i), 8'h01, 0, 0);
      for (int i = 2; i <= 5; i++)
         add(1, 0, 1, 3'b011, 8'h00, 8'h09, 8'(i), 0, 0);
      add(1, 1, 1, 3'b000, 8'h59, 8'h10, 8'h05, 0, 0);  // BCD units carry
      add(1, 1, 0, 3'b101, 8'h00, 8'h09, 8'h05, 0, 0);
      add(1, 1, 1, 3'b110, 8'h59, 8'h10, 8'h05, 0, 0);
      add(1, 1, 1, 3'b000, 8'h59, 8'h11, 8'h05, 0, 0);
      add(1, 0, 0, 3'b011, 8'h59, 8'h11, 8'h06, 0, 0);
      add(1, 0, 1, 3'b011, 8'h00, 8'h11, 8'h07, 0, 0);
      add(1, 0, 1, 3'b011, 8'h00, 8'h11, 8'h08, 0, 0);
      add(1, 0, 1, 3'b011, 8'h00, 8'h11, 8'h09, 0, 0);
      add(1, 0, 1, 3'b011, 8'h00, 8'h11, 8'h10, 0, 0);
      add(1, 1, 0, 3'b011, 8'h00, 8'h11, 8'h09, 0, 0);
`endif

      @(negedge clk_1Hz);
      foreach (vecs[i])
         apply($sformatf("vec%0d", i), vecs[i]);

      // Reset coincident with a pending run carry at the last minute of the day.
      hv = '{1'b0, 1'b1, 1'b1, 3'b000, 8'h00, 8'h00, c_GIO_RST, 1'b0, 1'b0};
      apply("rst_pre", hv);
      hv = '{1'b1, 1'b1, 1'b0, 3'b011, 8'h00, 8'h00, 8'h23, 1'b0, 1'b0};
`ifdef HOUR12_EN
      hv.e_gio = 8'h11;
`endif
      apply("set_gio", hv);
      hv.mode = 3'b101; hv.e_phut = 8'h59;
      apply("set_phut", hv);
      hv = '{1'b0, 1'b1, 1'b1, 3'b000, 8'h59, 8'h00, c_GIO_RST, 1'b0, 1'b0};
      apply("rst_vs_carry", hv);
      hv.rst_n = 1'b1; hv.giay = 8'h00;
      apply("rst_after", hv);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
